// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, a two-entry skid
// buffer (MAIN drives the outputs, SKID absorbs one beat) and synchronous flush.
module pipe_stage_skid_reg #(
    parameter int                 DATA_W    = 32,
    parameter int                 NUM_DATA  = 2,
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic                       in_pred_taken,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic                       out_pred_taken,
    output logic [1:0]                 occupancy
);

    logic                       mainValid;
    logic [NUM_DATA*DATA_W-1:0] mainData;
    logic [PC_W-1:0]            mainPc;
    logic [INSTR_W-1:0]         mainInstr;
    logic                       mainPred;

    logic                       skidValid;
    logic [NUM_DATA*DATA_W-1:0] skidData;
    logic [PC_W-1:0]            skidPc;
    logic [INSTR_W-1:0]         skidInstr;
    logic                       skidPred;

    logic inFire;
    logic outFire;

    // in_ready comes straight from the SKID valid flop, so out_ready never
    // reaches it combinationally.
    assign in_ready = ~skidValid;
    assign inFire   = in_valid & in_ready;
    assign outFire  = mainValid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mainValid <= 1'b0;
            mainData  <= '0;
            mainPc    <= '0;
            mainInstr <= NOP_INSTR;
            mainPred  <= 1'b0;
            skidValid <= 1'b0;
            skidData  <= '0;
            skidPc    <= '0;
            skidInstr <= '0;
            skidPred  <= 1'b0;
        end else if (flush) begin
            // Flush wins over everything; an incoming beat is dropped.
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainData  <= '0;
            mainPc    <= '0;
            mainInstr <= NOP_INSTR;
            mainPred  <= 1'b0;
        end else if (!mainValid || outFire) begin
            // MAIN is free this cycle: refill from SKID first to keep FIFO order.
            if (skidValid) begin
                mainValid <= 1'b1;
                mainData  <= skidData;
                mainPc    <= skidPc;
                mainInstr <= skidInstr;
                mainPred  <= skidPred;
                skidValid <= 1'b0;
            end else begin
                mainValid <= inFire;
                if (inFire) begin
                    mainData  <= in_data;
                    mainPc    <= in_pc;
                    mainInstr <= in_instr;
                    mainPred  <= in_pred_taken;
                end
            end
        end else if (inFire) begin
            skidValid <= 1'b1;
            skidData  <= in_data;
            skidPc    <= in_pc;
            skidInstr <= in_instr;
            skidPred  <= in_pred_taken;
        end
    end

    assign out_valid      = mainValid;
    assign out_data       = mainData;
    assign out_pc         = mainPc;
    // Bubbles never leak a stale instruction or prediction downstream.
    assign out_instr      = mainValid ? mainInstr : NOP_INSTR;
    assign out_pred_taken = mainValid & mainPred;
    assign occupancy      = {1'b0, mainValid} + {1'b0, skidValid};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: handshake, skid fill/drain, flush,
// bubble gating and asynchronous reset.
module tb_pipe_stage_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_pred_taken;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred_taken;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid_reg #(
        .DATA_W(32), .NUM_DATA(2), .PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_pc(in_pc), .in_instr(in_instr), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pc(out_pc), .out_instr(out_instr), .out_pred_taken(out_pred_taken),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [31:0] pc, input logic pred);
        in_valid      = v;
        in_pc         = pc;
        in_instr      = 32'hC000_0000 | pc;
        in_data       = {pc + 32'd1, pc};
        in_pred_taken = pred;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        beat(1'b0, 32'h0, 1'b0);
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_instr", out_instr, NOP);
        chk("rst_pc", out_pc, 0);
        chk("rst_data", out_data, 0);
        chk("rst_pred", out_pred_taken, 0);
        step();
        reset_n = 1'b1;

        // 1: single beat, one-cycle latency
        beat(1'b1, 32'h10, 1'b0);
        in_data = {32'd7, 32'd5};
        out_ready = 1'b1;
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_pc", out_pc, 32'h10);
        chk("t1_data", out_data, {32'd7, 32'd5});
        chk("t1_instr", out_instr, 32'hC000_0010);
        chk("t1_occ", occupancy, 1);
        beat(1'b0, 32'h0, 1'b0);
        step();
        chk("t1_empty_valid", out_valid, 0);
        chk("t1_empty_instr", out_instr, NOP);
        chk("t1_held_pc", out_pc, 32'h10);
        chk("t1_empty_occ", occupancy, 0);

        // 2: back-to-back stream at full throughput
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, 32'(i * 4), 1'b0);
            chk("t2_in_ready", in_ready, 1);
            step();
            chk("t2_valid", out_valid, 1);
            chk("t2_pc", out_pc, 64'(i * 4));
            chk("t2_occ", occupancy, 1);
        end
        beat(1'b0, 32'h0, 1'b0);
        step();
        chk("t2_drained", out_valid, 0);

        // 3: fill the skid with downstream stalled, then drain in order
        out_ready = 1'b0;
        beat(1'b1, 32'h100, 1'b0);
        step();
        chk("t3_occ1", occupancy, 1);
        chk("t3_ready1", in_ready, 1);
        beat(1'b1, 32'h104, 1'b0);
        step();
        chk("t3_occ2", occupancy, 2);
        chk("t3_ready0", in_ready, 0);
        beat(1'b1, 32'h108, 1'b0);
        step();
        chk("t3_still_full", occupancy, 2);
        chk("t3_stall_ready", in_ready, 0);
        chk("t3_stable_pc", out_pc, 32'h100);
        chk("t3_stable_instr", out_instr, 32'hC000_0100);
        out_ready = 1'b1;
        step();
        chk("t3_out1_pc", out_pc, 32'h104);
        chk("t3_ready_back", in_ready, 1);
        chk("t3_occ_after", occupancy, 1);
        step();
        chk("t3_out2_pc", out_pc, 32'h108);
        chk("t3_out2_valid", out_valid, 1);
        beat(1'b0, 32'h0, 1'b0);
        step();
        chk("t3_empty", out_valid, 0);

        // 4: flush while FULL with an incoming beat, held for two cycles
        out_ready = 1'b0;
        beat(1'b1, 32'h180, 1'b1);
        step();
        beat(1'b1, 32'h184, 1'b0);
        step();
        chk("t4_full", occupancy, 2);
        flush = 1'b1;
        beat(1'b1, 32'h200, 1'b1);
        step();
        chk("t4_valid", out_valid, 0);
        chk("t4_occ", occupancy, 0);
        chk("t4_instr", out_instr, NOP);
        chk("t4_pred", out_pred_taken, 0);
        chk("t4_pc_cleared", out_pc, 0);
        chk("t4_ready", in_ready, 1);
        step();
        chk("t4_hold_occ", occupancy, 0);
        chk("t4_hold_ready", in_ready, 1);
        flush = 1'b0;
        beat(1'b0, 32'h0, 1'b0);
        step();
        chk("t4_no_0x200", out_valid, 0);

        // 5: prediction bit visible while valid, gated once empty
        beat(1'b1, 32'h300, 1'b1);
        step();
        chk("t5_pred_on", out_pred_taken, 1);
        beat(1'b0, 32'h0, 1'b0);
        step();
        chk("t5_pred_held", out_pred_taken, 1);
        out_ready = 1'b1;
        step();
        chk("t5_pred_off", out_pred_taken, 0);
        chk("t5_occ", occupancy, 0);

        // 6: asynchronous reset mid-cycle with both entries full
        out_ready = 1'b0;
        beat(1'b1, 32'h400, 1'b0);
        step();
        beat(1'b1, 32'h404, 1'b1);
        step();
        chk("t6_full", occupancy, 2);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_occ", occupancy, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_pc", out_pc, 0);
        chk("t6_rst_instr", out_instr, NOP);
        #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        beat(1'b1, 32'h500, 1'b0);
        step();
        chk("t6_after_valid", out_valid, 1);
        chk("t6_after_pc", out_pc, 32'h500);
        beat(1'b0, 32'h0, 1'b0);
        step();
        chk("t6_final_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
